// File: rtl/adder_4bit_reg.sv
// Registered unsigned adder built from a ripple chain of full-adder cells.
// It produces a one-cycle-latency sum, carry, zero and signed-overflow result.

module adder_4bit_reg_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic p;

    assign p   = a_i ^ b_i;
    assign s_o = p ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & p);
endmodule

module adder_4bit_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             zero,
    output logic             overflow
);
    logic [WIDTH:0]   c_chain;
    logic [WIDTH-1:0] sum_n;
    logic             carry_n;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             carry_q,     carry_d;
    logic             zero_q,      zero_d;
    logic             overflow_q,  overflow_d;

    assign c_chain[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        adder_4bit_reg_fa u_fa (
            .a_i (a[i]),
            .b_i (b[i]),
            .c_i (c_chain[i]),
            .s_o (sum_n[i]),
            .c_o (c_chain[i+1])
        );
    end

    assign carry_n = c_chain[WIDTH];

    // Result registers load only on in_valid, so X on idle operands never reaches them.
    always_comb begin
        out_valid_d = in_valid;
        sum_d       = sum_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        if (in_valid) begin
            sum_d      = sum_n;
            carry_d    = carry_n;
            zero_d     = (sum_n == '0);
            overflow_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum_n[WIDTH-1] != a[WIDTH-1]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_adder_4bit_reg.sv
// Directed and exhaustive bench for adder_4bit_reg.
// Expected results are queued at drive time and compared one cycle later.

module tb_adder_4bit_reg;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic [3:0] sum;
    logic       carry;
    logic       zero;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       v;
        logic [3:0] s;
        logic       c;
        logic       z;
        logic       o;
    } exp_t;

    exp_t model;
    exp_t sb_q[$];

    adder_4bit_reg #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .sum       (sum),
        .carry     (carry),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard empty", tag);
            return;
        end
        e = sb_q.pop_front();
        check({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, e.v});
        check({tag, ".sum"},       {4'd0, sum},       {4'd0, e.s});
        check({tag, ".carry"},     {7'd0, carry},     {7'd0, e.c});
        check({tag, ".zero"},      {7'd0, zero},      {7'd0, e.z});
        check({tag, ".overflow"},  {7'd0, overflow},  {7'd0, e.o});
    endtask

    // Drive one cycle of stimulus, update the reference model, check after the edge.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [3:0] aa, input logic [3:0] bb);
        logic [4:0] full;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a        = aa;
        b        = bb;
        if (r) begin
            model = '0;
        end else if (v) begin
            full    = {1'b0, aa} + {1'b0, bb};
            model.v = 1'b1;
            model.s = full[3:0];
            model.c = full[4];
            model.z = (full[3:0] == 4'd0);
            model.o = (aa[3] == bb[3]) && (full[3] != aa[3]);
        end else begin
            model.v = 1'b0;
        end
        sb_q.push_back(model);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        model    = '0;

        step("reset0", 1'b1, 1'b0, 4'd0, 4'd0);
        step("reset1", 1'b1, 1'b0, 4'd0, 4'd0);

        step("v_0p0",   1'b0, 1'b1, 4'd0,  4'd0);
        step("v_1p2",   1'b0, 1'b1, 4'd1,  4'd2);
        step("v_5p3",   1'b0, 1'b1, 4'd5,  4'd3);
        step("v_15p1",  1'b0, 1'b1, 4'd15, 4'd1);
        step("v_10p10", 1'b0, 1'b1, 4'd10, 4'd10);
        step("v_15p15", 1'b0, 1'b1, 4'd15, 4'd15);

        step("hold_load", 1'b0, 1'b1, 4'd5,  4'd3);
        step("hold_idle", 1'b0, 1'b0, 4'd15, 4'd15);
        step("hold_idle2", 1'b0, 1'b0, 4'd15, 4'd15);
        step("hold_x",    1'b0, 1'b0, 4'bxxxx, 4'bxxxx);

        step("pre_rst",  1'b0, 1'b1, 4'd7,  4'd9);
        step("rst_prio", 1'b1, 1'b1, 4'd15, 4'd15);
        step("post_rst", 1'b0, 1'b0, 4'd3,  4'd4);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                step($sformatf("exh_%0d_%0d", i, j), 1'b0, 1'b1, 4'(i), 4'(j));
            end
        end

        step("tail_idle", 1'b0, 1'b0, 4'd0, 4'd0);

        checks++;
        assert (sb_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
